// File: rtl/regfile_dump.sv
// Register-file dump engine: walks an address range (wrapping modulo 2^REGBITS) through a
// combinational read port and presents each register as a valid/ready beat.
module regfile_dump #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [REGBITS-1:0] first_addr,
  input  logic [REGBITS-1:0] last_addr,
  output logic [REGBITS-1:0] ra,
  input  logic [WIDTH-1:0]   rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REGBITS-1:0] out_addr,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

  state_e             state;
  logic [REGBITS-1:0] cur;
  logic [REGBITS-1:0] last;
  logic [REGBITS-1:0] cur_inc;

  assign cur_inc = cur + REGBITS'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= StIdle;
      cur       <= '0;
      last      <= '0;
      ra        <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            cur   <= first_addr;
            last  <= last_addr;
            ra    <= first_addr;
            busy  <= 1'b1;
            state <= StRead;
          end
        end
        StRead: begin
          if (abort) begin
            out_valid <= 1'b0;
            ra        <= '0;
            busy      <= 1'b0;
            state     <= StIdle;
          end else begin
            out_data  <= rd;
            out_addr  <= ra;
            out_valid <= 1'b1;
            state     <= StSend;
          end
        end
        StSend: begin
          // Abort takes priority over a handshake in the same cycle: no done pulse.
          if (abort) begin
            out_valid <= 1'b0;
            ra        <= '0;
            busy      <= 1'b0;
            state     <= StIdle;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (cur == last) begin
              done  <= 1'b1;
              state <= StDone;
            end else begin
              cur   <= cur_inc;
              ra    <= cur_inc;
              state <= StRead;
            end
          end
        end
        StDone: begin
          ra    <= '0;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Randomised self-checking bench for regfile_dump: expected beats come from a queue built
// from the register array and the address range, then drained on each handshake.
module tb_regfile_dump;

  localparam int unsigned W = 16;
  localparam int unsigned RB = 4;
  localparam int NREG = 16;

  typedef struct {
    logic [RB-1:0] addr;
    logic [W-1:0]  data;
  } beat_t;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [RB-1:0] first_addr;
  logic [RB-1:0] last_addr;
  logic [RB-1:0] ra;
  logic [W-1:0]  rd;
  logic          out_valid;
  logic          out_ready;
  logic [RB-1:0] out_addr;
  logic [W-1:0]  out_data;
  logic          busy;
  logic          done;

  logic [W-1:0] mem [NREG];
  int n_checks = 0;
  int n_fail   = 0;

  assign rd = mem[ra];

  regfile_dump #(.WIDTH(W), .REGBITS(RB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .ra         (ra),
    .rd         (rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ra"}, 32'(ra), 0);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_addr"}, 32'(out_addr), 0);
    check({tag, "_data"}, 32'(out_data), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < NREG; i++) mem[i] = W'($urandom);
    mem[0] = '0;
  endtask

  // Called #1 after a clock edge with the DUT idle. abort_after = number of beats accepted
  // before abort is raised (-1: never); stall_addr = beat held off for 5 cycles (-1: none).
  task automatic run_dump(input int f, input int l, input int pct, input int stall_addr,
                          input int abort_after);
    beat_t q[$];
    int n, cyc, popped, stall_cnt;
    bit prev_hs, prev_hold, fin, rdy;
    logic [RB-1:0] h_addr;
    logic [W-1:0]  h_data;
    popped = 0; stall_cnt = 0; prev_hs = 0; prev_hold = 0; fin = 0;
    h_addr = '0; h_data = '0;
    n = (l - f + NREG) % NREG + 1;
    for (int i = 0; i < n; i++) q.push_back('{addr: RB'((f + i) % NREG), data: mem[(f + i) % NREG]});

    first_addr = RB'(f);
    last_addr  = RB'(l);
    start      = 1'b1;
    out_ready  = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_valid", 32'(out_valid), 0);
    check("start_ra", 32'(ra), 32'(f));

    cyc = 0;
    while (!fin && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      if (prev_hs && q.size() == 0) begin
        check("done_pulse", 32'(done), 1);
        check("done_valid", 32'(out_valid), 0);
        check("done_busy", 32'(busy), 1);
        fin = 1;
      end else begin
        check("no_done", 32'(done), 0);
        if (prev_hs) check("gap", 32'(out_valid), 0);
        else begin
          check("beat_valid", 32'(out_valid), 1);
          if (prev_hold) begin
            check("hold_addr", 32'(out_addr), 32'(h_addr));
            check("hold_data", 32'(out_data), 32'(h_data));
          end
        end
      end

      if (!fin && out_valid) begin
        if (abort_after == popped) begin
          abort = 1'b1; out_ready = 1'b1; start = 1'b0;
          @(posedge clk); #1;
          abort = 1'b0; out_ready = 1'b0;
          check("abort_valid", 32'(out_valid), 0);
          check("abort_ra", 32'(ra), 0);
          for (int k = 0; k < 3; k++) begin
            check("abort_busy", 32'(busy), 0);
            check("abort_no_done", 32'(done), 0);
            @(posedge clk); #1;
          end
          return;
        end
        if (stall_addr >= 0 && int'(out_addr) == stall_addr && stall_cnt < 5) begin
          rdy = 1'b0;
          stall_cnt++;
        end else begin
          rdy = ($urandom_range(0, 99) < pct);
        end
        out_ready = rdy;
        if (rdy) begin
          check("beat_addr", 32'(out_addr), 32'(q[0].addr));
          check("beat_data", 32'(out_data), 32'(q[0].data));
          void'(q.pop_front());
          popped++;
        end
        prev_hs = rdy; prev_hold = !rdy;
        h_addr = out_addr; h_data = out_data;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        prev_hs = 1'b0; prev_hold = 1'b0;
      end
      // Start pulses and address changes while busy must not disturb the dump.
      start      = (q.size() > 0) && !fin && ($urandom_range(0, 7) == 0);
      first_addr = RB'($urandom);
      last_addr  = RB'($urandom);
    end
    start = 1'b0;
    check("finished", 32'(fin), 1);
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 0);
    check("idle_ra", 32'(ra), 0);
    check("idle_done", 32'(done), 0);
    check("idle_valid", 32'(out_valid), 0);
  endtask

  initial begin
    int f, l, pct, ab, n;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    first_addr = '0; last_addr = '0;
    randomize_mem();
    #1;
    check_all_zero("reset");
    #20 reset_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("post_reset");

    mem[1] = 16'h1111; mem[2] = 16'h2222; mem[3] = 16'h3333;
    run_dump(1, 3, 100, -1, -1);
    run_dump(1, 3, 100, 2, -1);

    mem[14] = 16'hAAAA; mem[15] = 16'hBBBB; mem[1] = 16'h0101;
    run_dump(14, 1, 100, -1, -1);

    mem[5] = 16'h5A5A;
    run_dump(5, 5, 100, -1, -1);

    mem[1] = 16'h1111;
    run_dump(1, 3, 100, -1, 1);

    // Asynchronous reset between edges while a beat is waiting.
    first_addr = 4'd1; last_addr = 4'd3; start = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 10 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    check("rst_pre_valid", 32'(out_valid), 1);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    #1 reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rst_idle_busy", 32'(busy), 0);
      check("rst_idle_valid", 32'(out_valid), 0);
    end
    run_dump(0, 0, 100, -1, -1);

    for (int t = 0; t < 25; t++) begin
      randomize_mem();
      f = $urandom_range(0, NREG - 1);
      l = $urandom_range(0, NREG - 1);
      pct = $urandom_range(30, 100);
      n = (l - f + NREG) % NREG + 1;
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
      run_dump(f, l, pct, -1, ab);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
